seq_mac: RTL and testbench

SEQ_MAC -- requirements
Module: seq_mac

---
 rtl/seq_mac_pkg.sv | 25 ++
 rtl/seq_mac_shift_add_mul.sv | 96 +++++++++
 rtl/seq_mac.sv | 110 +++++++++++
 tb/tb_seq_mac.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mac_pkg.sv
// ---------------------------------------------------------------------------
// seq_mac_pkg
// Shared arithmetic package for the sequential multiply-accumulate block.
// Holds the controller state encoding, the default operand/accumulator
// widths and a small helper for sizing the multiply bit counter.
// No ports (package).
// ---------------------------------------------------------------------------
package seq_mac_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_ACC_W = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // A counter over n steps needs ceil(log2(n)) bits, but never fewer than one
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mac_shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Iterative unsigned multiplier: one multiplier bit per clock, so a product
// takes exactly N cycles after start regardless of operand values.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears every register
//   start_i    capture a_i/b_i/last_i, clear product and counter, begin
//   a_i, b_i   N-bit unsigned multiplicand / multiplier
//   last_i     "final term" tag travelling with the operand pair
//   done_o     high during the final multiply cycle; product_o is complete
//              from the following cycle on
//   product_o  2N-bit product register
//   last_o     captured last_i
// ---------------------------------------------------------------------------
module shift_add_mul
  import seq_mac_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic           last_i,
  output logic           done_o,
  output logic [2*N-1:0] product_o,
  output logic           last_o
);

  localparam int CW = cntWidth(N);

  logic [2*N-1:0] mcand_q, mcand_d;
  logic [2*N-1:0] prod_q,  prod_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic           busy_q,  busy_d;
  logic           last_q,  last_d;

  // The last multiply cycle is the one where the counter reaches N-1
  assign done_o = busy_q && (cnt_q == CW'(N - 1));

  // Next-state datapath: the multiplicand shifts left and the multiplier
  // shifts right each step, so bit 0 of the multiplier always selects
  // whether the current shifted multiplicand is added in.
  always_comb begin
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    last_d   = last_q;
    if (start_i) begin
      mcand_d  = {{N{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
      last_d   = last_i;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath registers; reset wipes any partial product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      last_q   <= last_d;
    end
  end

  assign product_o = prod_q;
  assign last_o    = last_q;

endmodule

// File: rtl/seq_mac.sv
// ---------------------------------------------------------------------------
// seq_mac
// Sequential dot-product engine: accepts unsigned operand pairs one at a
// time, multiplies each with an N-cycle shift-and-add, and accumulates the
// products with saturation until the pair tagged in_last, then offers the
// result on a valid/ready handshake.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand-pair handshake (ready only in IDLE)
//   A, B                 N-bit unsigned operands
//   in_last              pair closes the current dot product
//   out_valid/out_ready  result handshake (valid only in OUT)
//   Acc                  ACC_W-bit saturating accumulator
//   Ovf                  sticky saturation flag for the current result
// ---------------------------------------------------------------------------
module seq_mac
  import seq_mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] Acc,
  output logic             Ovf
);

  localparam int SW = ACC_W + 1;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             start;
  logic             mulDone;
  logic [2*N-1:0]   product;
  logic             lastCap;
  logic [SW-1:0]    sum_d;

  assign start = (state_q == IDLE) && in_valid;

  shift_add_mul #(
    .N(N)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .a_i      (A),
    .b_i      (B),
    .last_i   (in_last),
    .done_o   (mulDone),
    .product_o(product),
    .last_o   (lastCap)
  );

  // One extra bit of headroom exposes the carry that signals saturation
  assign sum_d = {1'b0, acc_q} + SW'(product);

  // Controller, accumulator and sticky overflow flag.  Ovf is only ever
  // set here and only cleared on the result handshake or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= MUL;
          end
        end
        MUL: begin
          if (mulDone) begin
            state_q <= ACC;
          end
        end
        ACC: begin
          if (sum_d[ACC_W]) begin
            acc_q <= '1;
            ovf_q <= 1'b1;
          end else begin
            acc_q <= sum_d[ACC_W-1:0];
          end
          state_q <= lastCap ? OUT : IDLE;
        end
        OUT: begin
          if (out_ready) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign Acc       = acc_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_seq_mac.sv
// ---------------------------------------------------------------------------
// tb_seq_mac
// Directed bench for seq_mac: a scoreboard queue holds the expected result
// of each dot product, computed from the operands as they are driven, and is
// popped when the block raises out_valid.  A second instance with ACC_W=8
// exercises saturation.  Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_seq_mac;

  typedef struct packed {
    logic [11:0] acc;
    logic        ovf;
  } expT;

  logic        clk = 1'b0;
  logic        rst;

  logic        inValid, inReady, inLast, outValid, outReady, ovf;
  logic [3:0]  a, b;
  logic [11:0] acc;

  logic        inValid8, inReady8, inLast8, outValid8, outReady8, ovf8;
  logic [3:0]  a8, b8;
  logic [7:0]  acc8;

  expT         sbQ[$];
  expT         sb8Q[$];
  int          modelSum;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  seq_mac #(.N(4), .ACC_W(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid),
    .in_ready (inReady),
    .A        (a),
    .B        (b),
    .in_last  (inLast),
    .out_valid(outValid),
    .out_ready(outReady),
    .Acc      (acc),
    .Ovf      (ovf)
  );

  seq_mac #(.N(4), .ACC_W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (inValid8),
    .in_ready (inReady8),
    .A        (a8),
    .B        (b8),
    .in_last  (inLast8),
    .out_valid(outValid8),
    .out_ready(outReady8),
    .Acc      (acc8),
    .Ovf      (ovf8)
  );

  // Single comparison point: counts the check and reports any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one pair to the 12-bit instance, update the model, and check the
  // busy window and what follows it (result latency or readiness again)
  task automatic applyStimulus(input logic [3:0] pa, input logic [3:0] pb, input logic pl);
    int  waitCnt;
    expT e;
    waitCnt = 0;
    while (inReady !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("readyBeforeAccept", 32'(inReady), 32'd1);
    a       = pa;
    b       = pb;
    inLast  = pl;
    inValid = 1'b1;
    modelSum += int'(pa) * int'(pb);
    if (pl) begin
      e.ovf = (modelSum > 4095);
      e.acc = e.ovf ? 12'hFFF : modelSum[11:0];
      sbQ.push_back(e);
      modelSum = 0;
    end
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checkOutput("inReadyLowBusy", 32'(inReady), 32'd0);
      checkOutput("outValidLowBusy", 32'(outValid), 32'd0);
      @(negedge clk);
    end
    if (pl) begin
      checkOutput("resultLatency", 32'(outValid), 32'd1);
    end else begin
      checkOutput("readyAfterAcc", 32'(inReady), 32'd1);
    end
  endtask

  // Pop the scoreboard, compare, optionally stall the consumer while
  // poking in_valid, then complete the handshake and check the clear
  task automatic collectResult(input int holdCycles);
    int          waitCnt;
    expT         e;
    logic [11:0] held;
    waitCnt = 0;
    while (outValid !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("outValidWait", 32'(outValid), 32'd1);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
    end else begin
      e = 'x;
    end
    checkOutput("accResult", 32'(acc), 32'(e.acc));
    checkOutput("ovfResult", 32'(ovf), 32'(e.ovf));
    held = e.acc;
    for (int k = 0; k < holdCycles; k++) begin
      outReady = 1'b0;
      inValid  = (k % 2 == 0);
      a        = 4'($urandom_range(15, 1));
      b        = 4'($urandom_range(15, 1));
      inLast   = 1'b1;
      @(negedge clk);
      checkOutput("holdOutValid", 32'(outValid), 32'd1);
      checkOutput("holdInReady", 32'(inReady), 32'd0);
      checkOutput("holdAcc", 32'(acc), 32'(held));
      checkOutput("holdOvf", 32'(ovf), 32'(e.ovf));
    end
    inValid  = 1'b0;
    inLast   = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    checkOutput("postHsOutValid", 32'(outValid), 32'd0);
    checkOutput("postHsInReady", 32'(inReady), 32'd1);
    checkOutput("postHsAcc", 32'(acc), 32'd0);
    checkOutput("postHsOvf", 32'(ovf), 32'd0);
  endtask

  initial begin
    expT e8;
    checks    = 0;
    errors    = 0;
    modelSum  = 0;
    rst       = 1'b1;
    inValid   = 1'b0;
    inLast    = 1'b0;
    outReady  = 1'b0;
    a         = '0;
    b         = '0;
    inValid8  = 1'b0;
    inLast8   = 1'b0;
    outReady8 = 1'b0;
    a8        = '0;
    b8        = '0;

    // Reset values
    @(negedge clk);
    checkOutput("rstInReady", 32'(inReady), 32'd1);
    checkOutput("rstOutValid", 32'(outValid), 32'd0);
    checkOutput("rstAcc", 32'(acc), 32'd0);
    checkOutput("rstOvf", 32'(ovf), 32'd0);
    checkOutput("rstInReady8", 32'(inReady8), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single pair 7*5
    applyStimulus(4'd7, 4'd5, 1'b1);
    collectResult(0);

    // Three-term dot product 6 + 16 + 225
    applyStimulus(4'd3, 4'd2, 1'b0);
    applyStimulus(4'd4, 4'd4, 1'b0);
    applyStimulus(4'd15, 4'd15, 1'b1);
    collectResult(0);

    // Zero multiplicand still takes the full multiply time
    applyStimulus(4'd0, 4'd15, 1'b1);
    collectResult(0);

    // Consumer stalls for five cycles while in_valid is poked
    applyStimulus(4'd6, 4'd7, 1'b1);
    collectResult(5);

    // Reset in the second multiply cycle discards a partial dot product
    applyStimulus(4'd9, 4'd9, 1'b0);
    a       = 4'd9;
    b       = 4'd9;
    inLast  = 1'b1;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    inLast  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midMulRstInReady", 32'(inReady), 32'd1);
    checkOutput("midMulRstOutValid", 32'(outValid), 32'd0);
    checkOutput("midMulRstAcc", 32'(acc), 32'd0);
    checkOutput("midMulRstOvf", 32'(ovf), 32'd0);
    modelSum = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(4'd2, 4'd3, 1'b1);
    collectResult(0);

    // Saturation on the 8-bit instance: 225 + 225 exceeds 255
    a8       = 4'd15;
    b8       = 4'd15;
    inLast8  = 1'b0;
    inValid8 = 1'b1;
    @(negedge clk);
    inValid8 = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("sat8ReadySecond", 32'(inReady8), 32'd1);
    inLast8  = 1'b1;
    inValid8 = 1'b1;
    e8.acc   = 12'd255;
    e8.ovf   = 1'b1;
    sb8Q.push_back(e8);
    @(negedge clk);
    inValid8 = 1'b0;
    inLast8  = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("sat8OutValid", 32'(outValid8), 32'd1);
    if (sb8Q.size() > 0) begin
      e8 = sb8Q.pop_front();
    end else begin
      e8 = 'x;
    end
    checkOutput("sat8Acc", 32'(acc8), 32'(e8.acc));
    checkOutput("sat8Ovf", 32'(ovf8), 32'(e8.ovf));
    outReady8 = 1'b1;
    @(negedge clk);
    outReady8 = 1'b0;
    checkOutput("sat8ClearAcc", 32'(acc8), 32'd0);
    checkOutput("sat8ClearOvf", 32'(ovf8), 32'd0);
    checkOutput("sat8ClearOutValid", 32'(outValid8), 32'd0);

    checkOutput("scoreboardDrained", 32'(sbQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
